safe_lockout_ctrl: RTL and testbench



---
 rtl/safe_lockout_ctrl_pkg.sv | 19 +
 rtl/safe_lockout_ctrl_if.sv | 46 ++++
 rtl/safe_lockout_ctrl_timer.sv | 38 +++
 rtl/safe_lockout_ctrl.sv | 154 +++++++++++++++
 tb/tb_safe_lockout_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/safe_lockout_ctrl_pkg.sv
// safe_lockout_ctrl_pkg
// Shared definitions for the brute-force lockout controller and its
// neighbours in the clk_1ms domain (master_fsm, top level).
//   lock_state_e     : controller state encoding (ARMED/LOCKED/GRACE)
//   DEF_*            : default parameter values for the controller
package safe_lockout_ctrl_pkg;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    LOCKED = 2'd1,
    GRACE  = 2'd2
  } lock_state_e;

  localparam int DEF_MAX_FAIL   = 3;
  localparam int DEF_LOCK_TICKS = 30000;
  localparam int DEF_MAX_SHIFT  = 3;
  localparam int DEF_CNT_W      = 18;

endpackage

// File: rtl/safe_lockout_ctrl_if.sv
// safe_lockout_ctrl_if
// Bundles the attempt report from master_fsm, the decoder count-enable
// path and the lockout status outputs.
//   attempt_done/attempt_ok : attempt report into the controller
//   cnten_in/cnten_out      : decoder count enable, raw and gated
//   lockout, blank_req, alarm, grace, fail_cnt, level, remain : status
//   state                   : current controller state (debug visibility)
//
// Handshake: there is no back-pressure. attempt_done is a single-cycle
// strobe sampled on every rising clk edge; attempt_ok is only meaningful
// on a cycle where attempt_done=1. Back-to-back strobes are each a
// separate attempt. The controller always accepts (it may ignore the
// attempt, e.g. while LOCKED).
interface safe_lockout_ctrl_if #(
  parameter int CNT_W = 18
);
  import safe_lockout_ctrl_pkg::*;

  logic             attempt_done;
  logic             attempt_ok;
  logic             cnten_in;
  logic             cnten_out;
  logic             lockout;
  logic             blank_req;
  logic             alarm;
  logic             grace;
  logic [3:0]       fail_cnt;
  logic [1:0]       level;
  logic [CNT_W-1:0] remain;
  lock_state_e      state;

  // master: attempt source and status consumer (master_fsm / top level)
  modport master (
    output attempt_done, attempt_ok, cnten_in,
    input  cnten_out, lockout, blank_req, alarm, grace,
    input  fail_cnt, level, remain, state
  );

  // slave: the lockout controller
  modport slave (
    input  attempt_done, attempt_ok, cnten_in,
    output cnten_out, lockout, blank_req, alarm, grace,
    output fail_cnt, level, remain, state
  );

endinterface

// File: rtl/safe_lockout_ctrl_timer.sv
// safe_lockout_ctrl_timer
// Loadable down-counter used as the lockout timer. Counts down by one per
// clock while non-zero and parks at zero.
//   clk, rst     : clock, asynchronous active-high reset
//   i_load       : load i_load_val this cycle (takes priority over counting)
//   i_load_val   : value to load
//   o_count      : current count (ticks remaining)
//   o_running    : count is non-zero
//   o_expire     : count is 1, i.e. this is the last counting cycle
module safe_lockout_ctrl_timer #(
  parameter int CNT_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_count,
  output logic             o_running,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_count   = r_count;
  assign o_running = (r_count != '0);
  assign o_expire  = (r_count == CNT_W'(1));

endmodule

// File: rtl/safe_lockout_ctrl.sv
// safe_lockout_ctrl
// Brute-force protection for the combination-entry path. Counts
// consecutive failed attempts; after MAX_FAIL of them it locks the entry
// path (gates cnten, requests display blanking) for LOCK_TICKS << level
// cycles, then allows one grace attempt. A failed grace attempt relocks
// with the escalation level raised (saturating at MAX_SHIFT); a correct
// one re-arms with level cleared.
//   clk  : clk_1ms, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : safe_lockout_ctrl_if.slave (attempt in, cnten path, status out)
module safe_lockout_ctrl
  import safe_lockout_ctrl_pkg::*;
#(
  parameter int MAX_FAIL   = DEF_MAX_FAIL,
  parameter int LOCK_TICKS = DEF_LOCK_TICKS,
  parameter int MAX_SHIFT  = DEF_MAX_SHIFT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  safe_lockout_ctrl_if.slave    bus
);

  if ((64'(LOCK_TICKS) << MAX_SHIFT) >= (64'd1 << CNT_W)) begin : g_chk_width
    $error("safe_lockout_ctrl: LOCK_TICKS << MAX_SHIFT does not fit in CNT_W bits");
  end
  if (MAX_FAIL < 1 || MAX_FAIL > 15) begin : g_chk_fail
    $error("safe_lockout_ctrl: MAX_FAIL must be 1..15");
  end
  if (MAX_SHIFT < 0 || MAX_SHIFT > 3) begin : g_chk_shift
    $error("safe_lockout_ctrl: MAX_SHIFT must be 0..3 (level is 2 bits)");
  end

  lock_state_e      r_state;
  lock_state_e      w_next_state;
  logic [3:0]       r_fail_cnt;
  logic [3:0]       w_next_fail;
  logic [1:0]       r_level;
  logic [1:0]       w_next_level;
  logic             r_lockout;
  logic             r_grace;
  logic             r_alarm;

  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_remain;
  logic             w_running;
  logic             w_expire;

  logic [4:0]       w_fail_inc;
  logic [1:0]       w_level_up;
  logic [CNT_W-1:0] w_len_cur;
  logic [CNT_W-1:0] w_len_up;

  assign w_fail_inc = {1'b0, r_fail_cnt} + 5'd1;
  assign w_level_up = (r_level >= 2'(MAX_SHIFT)) ? 2'(MAX_SHIFT) : (r_level + 2'd1);
  // Lockout length is computed from the level that will be in force
  // during the lockout: current level from ARMED, raised level from GRACE.
  assign w_len_cur  = CNT_W'(LOCK_TICKS) << r_level;
  assign w_len_up   = CNT_W'(LOCK_TICKS) << w_level_up;

  safe_lockout_ctrl_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_count    (w_remain),
    .o_running  (w_running),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ARMED;
      r_fail_cnt <= 4'd0;
      r_level    <= 2'd0;
      r_lockout  <= 1'b0;
      r_grace    <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_fail_cnt <= w_next_fail;
      r_level    <= w_next_level;
      r_lockout  <= (w_next_state == LOCKED);
      r_grace    <= (w_next_state == GRACE);
      // Every entry into LOCKED loads the timer, so the load strobe
      // registered is exactly the first lockout cycle.
      r_alarm    <= w_load;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_fail  = r_fail_cnt;
    w_next_level = r_level;
    w_load       = 1'b0;
    w_load_val   = '0;
    case (r_state)
      ARMED: begin
        if (bus.attempt_done) begin
          if (bus.attempt_ok) begin
            w_next_fail  = 4'd0;
            w_next_level = 2'd0;
          end else if (w_fail_inc >= 5'(MAX_FAIL)) begin
            w_next_state = LOCKED;
            w_next_fail  = 4'd0;
            w_load       = 1'b1;
            w_load_val   = w_len_cur;
          end else begin
            w_next_fail  = w_fail_inc[3:0];
          end
        end
      end
      LOCKED: begin
        // Attempts are ignored here, including on the expiry cycle.
        // The !w_running term only guards against sitting in LOCKED
        // with an idle timer.
        if (w_expire || !w_running) begin
          w_next_state = GRACE;
        end
      end
      GRACE: begin
        if (bus.attempt_done) begin
          if (bus.attempt_ok) begin
            w_next_state = ARMED;
            w_next_fail  = 4'd0;
            w_next_level = 2'd0;
          end else begin
            w_next_state = LOCKED;
            w_next_level = w_level_up;
            w_load       = 1'b1;
            w_load_val   = w_len_up;
          end
        end
      end
      default: begin
        w_next_state = ARMED;
      end
    endcase
  end

  assign bus.cnten_out = bus.cnten_in & ~r_lockout;
  assign bus.lockout   = r_lockout;
  assign bus.blank_req = r_lockout;
  assign bus.alarm     = r_alarm;
  assign bus.grace     = r_grace;
  assign bus.fail_cnt  = r_fail_cnt;
  assign bus.level     = r_level;
  assign bus.remain    = w_remain;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_safe_lockout_ctrl.sv
// tb_safe_lockout_ctrl
// Directed bench for safe_lockout_ctrl with MAX_FAIL=3, LOCK_TICKS=10,
// MAX_SHIFT=2, CNT_W=8. Stimulus tasks push the hand-computed outcome of
// each attempt into exp_q and the expected level/length of each lockout
// into exp_lock_q; two monitor processes pop and compare.
module tb_safe_lockout_ctrl;
  import safe_lockout_ctrl_pkg::*;

  localparam int CNT_W = 8;
  localparam int W     = 9;   // {fail_cnt[3:0], level[1:0], lockout, grace, alarm}
  localparam int LW    = 10;  // {level[1:0], length[7:0]}

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0]  exp_q[$];
  logic [LW-1:0] exp_lock_q[$];

  safe_lockout_ctrl_if #(.CNT_W(CNT_W)) bus ();

  safe_lockout_ctrl #(
    .MAX_FAIL   (3),
    .LOCK_TICKS (10),
    .MAX_SHIFT  (2),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / watchdog
  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete (time %0t)", $time);
    n_checks++;
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input int fc, input int lv, input bit lk,
                                      input bit gr, input bit al);
    return {4'(fc), 2'(lv), lk, gr, al};
  endfunction

  // driver tasks
  task automatic do_attempt(input bit ok, input logic [W-1:0] e);
    @(negedge clk);
    bus.attempt_done = 1'b1;
    bus.attempt_ok   = ok;
    exp_q.push_back(e);
  endtask

  task automatic do_fail_lock(input int fc, input int lv, input bit lk,
                              input bit gr, input bit al, input int lock_lv,
                              input int lock_len);
    do_attempt(1'b0, mk(fc, lv, lk, gr, al));
    exp_lock_q.push_back({2'(lock_lv), 8'(lock_len)});
  endtask

  task automatic release_in();
    @(negedge clk);
    bus.attempt_done = 1'b0;
    bus.attempt_ok   = 1'b0;
  endtask

  task automatic wait_grace(input int max_cyc);
    int n;
    n = 0;
    while (bus.grace !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("wait_grace", int'(bus.grace), 1);
  endtask

  task automatic wait_remain(input int val, input int max_cyc);
    int n;
    n = 0;
    while (int'(bus.remain) != val && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("wait_remain", int'(bus.remain), val);
  endtask

  // monitor: outcome of every attempt strobe, one cycle after it is sampled
  initial begin : attempt_mon
    logic hit;
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      hit = bus.attempt_done & ~rst;
      #2;
      if (hit) begin
        if (exp_q.size() == 0) begin
          check("attempt_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("att_fail_cnt", int'(bus.fail_cnt), int'(e[8:5]));
          check("att_level",    int'(bus.level),    int'(e[4:3]));
          check("att_lockout",  int'(bus.lockout),  int'(e[2]));
          check("att_blank",    int'(bus.blank_req), int'(e[2]));
          check("att_grace",    int'(bus.grace),    int'(e[1]));
          check("att_alarm",    int'(bus.alarm),    int'(e[0]));
          check("att_cnten",    int'(bus.cnten_out), int'(bus.cnten_in & ~e[2]));
        end
      end
    end
  end

  // monitor: every lockout episode, from alarm to the drop of lockout
  initial begin : lock_mon
    bit active;
    int cnt;
    int exp_len;
    logic [LW-1:0] r;
    active = 0;
    cnt = 0;
    exp_len = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        active = 0;
      end else begin
        if (bus.alarm) begin
          check("alarm_while_locked", int'(active), 0);
          if (exp_lock_q.size() == 0) begin
            check("alarm_unexpected", 1, 0);
            active = 0;
          end else begin
            r = exp_lock_q.pop_front();
            exp_len = int'(r[7:0]);
            check("lock_level", int'(bus.level), int'(r[9:8]));
            check("lock_start_lockout", int'(bus.lockout), 1);
            active = 1;
            cnt = 0;
          end
        end
        if (active) begin
          if (bus.lockout) begin
            check("lock_remain", int'(bus.remain), exp_len - cnt);
            check("lock_cnten_gated", int'(bus.cnten_out), 0);
            check("lock_blank", int'(bus.blank_req), 1);
            cnt++;
          end else begin
            check("lock_length", cnt, exp_len);
            check("lock_end_grace", int'(bus.grace), 1);
            check("lock_end_remain", int'(bus.remain), 0);
            active = 0;
          end
        end
      end
    end
  end

  // main stimulus
  initial begin
    bus.attempt_done = 1'b0;
    bus.attempt_ok   = 1'b0;
    bus.cnten_in     = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("rst_state",    int'(bus.state), int'(ARMED));
    check("rst_fail_cnt", int'(bus.fail_cnt), 0);
    check("rst_level",    int'(bus.level), 0);
    check("rst_remain",   int'(bus.remain), 0);
    check("rst_lockout",  int'(bus.lockout), 0);
    check("rst_blank",    int'(bus.blank_req), 0);
    check("rst_alarm",    int'(bus.alarm), 0);
    check("rst_grace",    int'(bus.grace), 0);
    check("rst_cnten",    int'(bus.cnten_out), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: two failures then a correct attempt
    do_attempt(1'b0, mk(1, 0, 0, 0, 0));
    do_attempt(1'b0, mk(2, 0, 0, 0, 0));
    do_attempt(1'b1, mk(0, 0, 0, 0, 0));
    release_in();

    // 2: three failures -> 10-cycle lockout at level 0
    do_attempt(1'b0, mk(1, 0, 0, 0, 0));
    do_attempt(1'b0, mk(2, 0, 0, 0, 0));
    do_fail_lock(0, 0, 1, 0, 1, 0, 10);
    release_in();
    wait_grace(40);

    // 3: escalation 20, 40, then saturated 40
    do_fail_lock(0, 1, 1, 0, 1, 1, 20);
    release_in();
    wait_grace(60);
    do_fail_lock(0, 2, 1, 0, 1, 2, 40);
    release_in();
    wait_grace(80);
    do_fail_lock(0, 2, 1, 0, 1, 2, 40);
    release_in();
    wait_grace(80);

    // 4: correct grace attempt re-arms at level 0, then a 10-cycle lockout
    do_attempt(1'b1, mk(0, 0, 0, 0, 0));
    do_attempt(1'b0, mk(1, 0, 0, 0, 0));
    do_attempt(1'b0, mk(2, 0, 0, 0, 0));
    do_fail_lock(0, 0, 1, 0, 1, 0, 10);

    // 5: attempts during LOCKED (back to back) are ignored
    do_attempt(1'b0, mk(0, 0, 1, 0, 0));
    do_attempt(1'b0, mk(0, 0, 1, 0, 0));
    do_attempt(1'b1, mk(0, 0, 1, 0, 0));
    release_in();
    wait_remain(1, 40);
    // strobe sampled on the expiry edge: still LOCKED then, so ignored
    bus.attempt_done = 1'b1;
    bus.attempt_ok   = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 1, 0));
    release_in();
    do_attempt(1'b1, mk(0, 0, 0, 0, 0));
    release_in();

    // 6: asynchronous reset in the middle of a level-1 lockout
    do_attempt(1'b0, mk(1, 0, 0, 0, 0));
    do_attempt(1'b0, mk(2, 0, 0, 0, 0));
    do_fail_lock(0, 0, 1, 0, 1, 0, 10);
    release_in();
    wait_grace(40);
    do_fail_lock(0, 1, 1, 0, 1, 1, 20);
    release_in();
    wait_remain(5, 40);
    check("pre_rst_lockout", int'(bus.lockout), 1);
    #1 rst = 1'b1;
    #1;
    check("arst_lockout",  int'(bus.lockout), 0);
    check("arst_blank",    int'(bus.blank_req), 0);
    check("arst_remain",   int'(bus.remain), 0);
    check("arst_level",    int'(bus.level), 0);
    check("arst_fail_cnt", int'(bus.fail_cnt), 0);
    check("arst_grace",    int'(bus.grace), 0);
    check("arst_alarm",    int'(bus.alarm), 0);
    check("arst_state",    int'(bus.state), int'(ARMED));
    check("arst_cnten_hi", int'(bus.cnten_out), 1);
    bus.cnten_in = 1'b0;
    #1;
    check("arst_cnten_lo", int'(bus.cnten_out), 0);
    bus.cnten_in = 1'b1;
    #1;
    check("arst_cnten_hi2", int'(bus.cnten_out), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_attempt(1'b0, mk(1, 0, 0, 0, 0));
    release_in();
    repeat (3) @(negedge clk);

    check("exp_q_drained", exp_q.size(), 0);
    check("exp_lock_q_drained", exp_lock_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
